// File: rtl/button_event_decoder_if.sv
// Button event bus: debounced level in, single-cycle user events and held flag out.
interface button_event_decoder_if;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_level,
        input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  btn_level,
        output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced active-low button level into press/release/click/long/repeat
// single-cycle events plus a held flag; all outputs are registered.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_decoder_if.slave  bus
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic             r_btn_s_p0;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press_p1;
    logic             r_release_p1;
    logic             r_click_p1;
    logic             r_long_p1;
    logic             r_repeat_p1;
    logic             r_held_p1;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_release;
    logic             w_click;
    logic             w_long;
    logic             w_repeat;

    // Stage p0: input register; reset to released so a button held through reset reads as a new press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s_p0 <= 1'b1;
        end else begin
            r_btn_s_p0 <= bus.btn_level;
        end
    end

    // Stage p1: FSM decode; a release always beats a threshold hit in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_btn_s_p0) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end
            end
            PRESSED: begin
                if (r_btn_s_p0) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_click     = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = LONG_HELD;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (r_btn_s_p0) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_repeat    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_press_p1   <= 1'b0;
            r_release_p1 <= 1'b0;
            r_click_p1   <= 1'b0;
            r_long_p1    <= 1'b0;
            r_repeat_p1  <= 1'b0;
            r_held_p1    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_press_p1   <= w_press;
            r_release_p1 <= w_release;
            r_click_p1   <= w_click;
            r_long_p1    <= w_long;
            r_repeat_p1  <= w_repeat;
            r_held_p1    <= (w_state_nxt != IDLE);
        end
    end

    assign bus.press_pulse   = r_press_p1;
    assign bus.release_pulse = r_release_p1;
    assign bus.click_pulse   = r_click_p1;
    assign bus.long_pulse    = r_long_p1;
    assign bus.repeat_pulse  = r_repeat_p1;
    assign bus.held          = r_held_p1;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3;
// per-cycle expectations are hand-written bit masks indexed by cycle number.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    button_event_decoder_if bus();

    button_event_decoder #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Bit n of low_m: button driven low after edge n. Bit n of other masks: output expected after edge n.
    task automatic run_scn(input string name, input logic [31:0] low_m,
                           input logic [31:0] press_m, input logic [31:0] rel_m,
                           input logic [31:0] click_m, input logic [31:0] long_m,
                           input logic [31:0] rep_m, input logic [31:0] held_m,
                           input int ncyc);
        bus.btn_level = ~low_m[0];
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s press c%0d", name, n),   bus.press_pulse,   press_m[n]);
            check($sformatf("%s release c%0d", name, n), bus.release_pulse, rel_m[n]);
            check($sformatf("%s click c%0d", name, n),   bus.click_pulse,   click_m[n]);
            check($sformatf("%s long c%0d", name, n),    bus.long_pulse,    long_m[n]);
            check($sformatf("%s repeat c%0d", name, n),  bus.repeat_pulse,  rep_m[n]);
            check($sformatf("%s held c%0d", name, n),    bus.held,          held_m[n]);
            bus.btn_level = ~low_m[n];
        end
    endtask

    initial begin
        bus.btn_level = 1'b1;
        #12;
        check("rst press",   bus.press_pulse,   1'b0);
        check("rst release", bus.release_pulse, 1'b0);
        check("rst click",   bus.click_pulse,   1'b0);
        check("rst long",    bus.long_pulse,    1'b0);
        check("rst repeat",  bus.repeat_pulse,  1'b0);
        check("rst held",    bus.held,          1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_scn("idle", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 20);

        // Low 5 cycles: press@2, release+click@7, held 2..6
        run_scn("short", 32'h1F, 32'h4, 32'h80, 32'h80, 32'h0, 32'h0, 32'h7C, 12);

        // Low 20 cycles: press@2, long@10, repeat@13,16,19, release@22 without click
        run_scn("long", 32'hFFFFF, 32'h4, 32'h400000, 32'h0, 32'h400, 32'h92000,
                32'h3FFFFC, 26);

        // Low 8 cycles: release lands on the threshold cycle, so click and no long
        run_scn("thresh", 32'hFF, 32'h4, 32'h400, 32'h400, 32'h0, 32'h0, 32'h3FC, 14);

        // 0,1,0: press@2, click@3, press@4, click@5
        run_scn("b2b", 32'h5, 32'h14, 32'h28, 32'h28, 32'h0, 32'h0, 32'h14, 8);

        // Reset asynchronously while in LONG_HELD, then release reset with button still low
        bus.btn_level = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid pre held", bus.held, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid async held",    bus.held,          1'b0);
        check("mid async release", bus.release_pulse, 1'b0);
        check("mid async repeat",  bus.repeat_pulse,  1'b0);
        @(posedge clk);
        #1;
        check("mid rst release", bus.release_pulse, 1'b0);
        check("mid rst held",    bus.held,          1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after rst press c1", bus.press_pulse, 1'b0);
        check("after rst held c1",  bus.held,        1'b0);
        @(posedge clk);
        #1;
        check("after rst press c2",   bus.press_pulse,   1'b1);
        check("after rst held c2",    bus.held,          1'b1);
        check("after rst release c2", bus.release_pulse, 1'b0);
        bus.btn_level = 1'b1;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
